shift_seq_ctrl: RTL

Sequential shift controller that serialises multi-bit shift operations onto a single-bit shift stage. It sequences one bit position per clock under a start/done handshake. It supports logical and arithmetic shifts in both directions and holds the result until the next operation. It sits beside the combinational shift/concatenation operators for requesters that trade latency for area and need a registered, handshaked result.

---
 rtl/shift_seq_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - sequential one-bit-per-cycle shift controller with start/done handshake
//
// Purpose:
//   Serialises a multi-bit shift onto a single-bit shift stage. An accepted start
//   loads the operand into the result register, then one bit position is shifted
//   per clock until the (clamped) amount is exhausted. The result is held until
//   the next accepted start.
//
// Optional feature macro: SHIFT_SEQ_ROTATE_EN
//   defined   : op 100 = ROL, op 101 = ROR (amount not clamped), op 110/111 = LSL
//   undefined : op[2] ignored, op decodes as op[1:0]
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, accepted when IDLE or DONE
//   op     in   [2:0] 000 LSL, 001 ASL, 010 LSR, 011 ASR, 100 ROL, 101 ROR
//   din    in   [WIDTH-1:0] operand
//   amt    in   [AMT_W-1:0] shift amount
//   busy   out  high while shifting
//   done   out  one-cycle pulse, dout valid
//   dout   out  [WIDTH-1:0] result register

module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step;
  logic [AMT_W-1:0] cnt_load;
  logic             is_rot;

  // One-bit step of the held result. The raw op code is stored so that every
  // op bit participates in the decode; aliasing is resolved here.
  always_comb begin
    step = {dout_q[WIDTH-2:0], 1'b0};
    case (op_q)
`ifdef SHIFT_SEQ_ROTATE_EN
      3'b000, 3'b001, 3'b110, 3'b111: step = {dout_q[WIDTH-2:0], 1'b0};
      3'b010:                         step = {1'b0, dout_q[WIDTH-1:1]};
      3'b011:                         step = {dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
      3'b100:                         step = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
      3'b101:                         step = {dout_q[0], dout_q[WIDTH-1:1]};
`else
      3'b000, 3'b001, 3'b100, 3'b101: step = {dout_q[WIDTH-2:0], 1'b0};
      3'b010, 3'b110:                 step = {1'b0, dout_q[WIDTH-1:1]};
      3'b011, 3'b111:                 step = {dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
`endif
      default:                        step = {dout_q[WIDTH-2:0], 1'b0};
    endcase
  end

  // Shifts past WIDTH cannot change the result, so the count is clamped.
  // Rotates are periodic, not saturating, so they run the full amount.
  always_comb begin
`ifdef SHIFT_SEQ_ROTATE_EN
    is_rot = (op == 3'b100) || (op == 3'b101);
`else
    is_rot = 1'b0;
`endif
    if (is_rot || (amt <= AMT_W'(WIDTH))) begin
      cnt_load = amt;
    end else begin
      cnt_load = AMT_W'(WIDTH);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dout_d  = din;
          op_d    = op;
          cnt_d   = cnt_load;
          state_d = (cnt_load == '0) ? S_DONE : S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        dout_d = step;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flags are registered from the next state so they line up with it.
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;

endmodule
